// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared encodings for the MMIO bus controller: CPU command codes,
// controller FSM states and the I/O window bases.
package mmio_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        M_NONE    = 2'b00,
        M_READ    = 2'b01,
        M_WRITE   = 2'b10,
        M_ILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_e;

    localparam logic [7:0] IN_BASE  = 8'h00;
    localparam logic [7:0] OUT_BASE = 8'h80;

    // True when off falls inside [base, base+n); wraps safely in 8 bits.
    function automatic logic in_window(logic [7:0] off, logic [7:0] base, int unsigned n);
        logic [7:0] rel;
        rel = off - base;
        return rel < 8'(n);
    endfunction

endpackage

// File: rtl/mmio_bus_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous input port word.
module mmio_sync2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// CPU-side MMIO controller: routes accesses to a pipelined RAM or to
// synchronized input / registered output ports, flagging bad accesses.
module mmio_bus_ctrl
    import mmio_bus_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 2,
    parameter int RAM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mem_cmd,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_ready,
    output logic [ADDR_W-2:0]       ram_addr,
    output logic                    ram_write,
    output logic [DATA_W-1:0]       ram_din,
    input  logic [DATA_W-1:0]       ram_dout,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic                    bus_err,
    input  logic                    err_clr
);

    localparam int RA_W  = ADDR_W - 1;
    localparam int CNT_W = 2;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [RA_W-1:0]              addr_q, addr_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
    logic                         bus_err_q, bus_err_d;

    logic [N_IN-1:0][DATA_W-1:0]  in_sync;
    mem_cmd_e                     cmd;
    logic [7:0]                   io_off;
    logic                         is_io, hit_in, hit_out;
    logic [DATA_W-1:0]            in_val, out_val;
    logic                         err_evt, ram_wr_en;

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        mmio_sync2 #(.DATA_W(DATA_W)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (in_port[g*DATA_W +: DATA_W]),
            .q_o   (in_sync[g])
        );
    end

    assign cmd     = mem_cmd_e'(mem_cmd);
    assign io_off  = mem_addr[7:0];
    assign is_io   = mem_addr[ADDR_W-1];
    assign hit_in  = is_io && in_window(io_off, IN_BASE, N_IN);
    assign hit_out = is_io && in_window(io_off, OUT_BASE, N_OUT);

    always_comb begin
        in_val  = '0;
        out_val = '0;
        for (int i = 0; i < N_IN; i++)
            if (io_off - IN_BASE == 8'(i)) in_val = in_sync[i];
        for (int i = 0; i < N_OUT; i++)
            if (io_off - OUT_BASE == 8'(i)) out_val = out_q[i];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        out_d     = out_q;
        err_evt   = 1'b0;
        ram_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd != M_NONE) begin
                    addr_d  = mem_addr[RA_W-1:0];
                    state_d = DONE;
                    case (cmd)
                        M_READ: begin
                            if (!is_io) begin
                                state_d = RAM_WAIT;
                                cnt_d   = '0;
                            end else if (hit_in) begin
                                rdata_d = in_val;
                            end else if (hit_out) begin
                                rdata_d = out_val;
                            end else begin
                                rdata_d = '0;
                                err_evt = 1'b1;
                            end
                        end
                        M_WRITE: begin
                            if (!is_io) begin
                                ram_wr_en = 1'b1;
                            end else if (hit_out) begin
                                for (int i = 0; i < N_OUT; i++)
                                    if (io_off - OUT_BASE == 8'(i)) out_d[i] = wdata;
                            end else begin
                                err_evt = 1'b1;
                            end
                        end
                        default: begin
                            rdata_d = '0;
                            err_evt = 1'b1;
                        end
                    endcase
                end
            end
            RAM_WAIT: begin
                // RAM has had RAM_LAT edges since the address was presented.
                if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
                    rdata_d = ram_dout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A fresh error wins over a simultaneous clear.
        bus_err_d = (bus_err_q & ~err_clr) | err_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            out_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Hold the accepted address while the RAM pipeline drains.
    assign ram_addr  = (state_q == IDLE) ? mem_addr[RA_W-1:0] : addr_q;
    assign ram_din   = wdata;
    assign ram_write = ram_wr_en & ~reset;
    assign rdata     = rdata_q;
    assign mem_ready = (state_q == DONE);
    assign out_port  = out_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl with a behavioural pipelined RAM (RAM_LAT=2).
module tb_mmio_bus_ctrl;
    import mmio_bus_ctrl_pkg::*;

    localparam int DW = 16, AW = 9, NI = 2, NO = 2, LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mem_cmd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              mem_ready;
    logic [AW-2:0]     ram_addr;
    logic              ram_write;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_dout;
    logic [NI*DW-1:0]  in_port;
    logic [NO*DW-1:0]  out_port;
    logic              bus_err;
    logic              err_clr;

    typedef struct {
        logic          is_rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] rpipe [LAT];

    always #5 clk = ~clk;

    mmio_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_OUT(NO), .RAM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready), .ram_addr(ram_addr),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
        .in_port(in_port), .out_port(out_port), .bus_err(bus_err), .err_clr(err_clr)
    );

    // RAM model: address sampled each edge, data appears LAT edges later.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (ram_write) begin
            ram[ram_addr] <= ram_din;
        end
        rpipe[0] <= ram[ram_addr];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[LAT-1];

    // Completion monitor: each mem_ready pops one expectation.
    always @(negedge clk) begin
        if (ram_write) wr_cnt++;
        if (reset) last_rd = '0;
        if (mem_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: rdata=%h with empty scoreboard", rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_rd) last_rd = e.data;
                if (rdata !== last_rd) begin
                    errors++;
                    $display("FAIL rdata_%s: got %h expected %h", e.is_rd ? "read" : "hold", rdata, last_rd);
                end
            end
        end
    end

    task automatic do_access(input logic [1:0] cmd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic is_rd,
                             input logic [DW-1:0] exp, input logic clr, output int lat);
        @(negedge clk);
        mem_cmd = cmd; mem_addr = addr; wdata = wd; err_clr = clr;
        sb_q.push_back('{is_rd, exp});
        @(posedge clk);
        @(negedge clk);
        mem_cmd = M_NONE; err_clr = 1'b0;
        lat = 1;
        while (!mem_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_cmd = M_NONE; mem_addr = '0; wdata = '0;
        in_port = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (mem_ready !== 0)  begin errors++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
        checks++; if (ram_write !== 0)  begin errors++; $display("FAIL reset_ram_write: got %b expected 0", ram_write); end
        checks++; if (out_port !== '0)  begin errors++; $display("FAIL reset_out_port: got %h expected 0", out_port); end
        checks++; if (bus_err !== 0)    begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        reset = 1'b0;
    endtask

    task automatic test_ram();
        int lat, w0;
        w0 = wr_cnt;
        do_access(M_WRITE, 9'h005, 16'h1234, 1'b0, 16'h0, 1'b0, lat);
        checks++; if (lat != 1)          begin errors++; $display("FAIL ram_wr_lat: got %0d expected 1", lat); end
        checks++; if (wr_cnt - w0 != 1)  begin errors++; $display("FAIL ram_wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (ram[5] !== 16'h1234) begin errors++; $display("FAIL ram_wr_data: got %h expected 1234", ram[5]); end
        w0 = wr_cnt;
        do_access(M_READ, 9'h005, 16'h0, 1'b1, 16'h1234, 1'b0, lat);
        checks++; if (lat != LAT + 1)    begin errors++; $display("FAIL ram_rd_lat: got %0d expected %0d", lat, LAT + 1); end
        checks++; if (wr_cnt != w0)      begin errors++; $display("FAIL ram_rd_no_write: got %0d writes expected 0", wr_cnt - w0); end
        do_access(M_WRITE, 9'h0FF, 16'hBEEF, 1'b0, 16'h0, 1'b0, lat);
        do_access(M_READ, 9'h0FF, 16'h0, 1'b1, 16'hBEEF, 1'b0, lat);
        checks++; if (bus_err !== 0)     begin errors++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_io_in();
        int lat;
        in_port = {16'h5A3C, 16'h00A5};
        repeat (2) @(negedge clk);
        do_access(M_READ, 9'h100, 16'h0, 1'b1, 16'h00A5, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL io_rd_lat: got %0d expected 1", lat); end
        do_access(M_READ, 9'h101, 16'h0, 1'b1, 16'h5A3C, 1'b0, lat);
        // New value changed together with the command is still in flight through the synchronizer.
        @(negedge clk);
        in_port[15:0] = 16'h1111;
        mem_cmd = M_READ; mem_addr = 9'h100;
        sb_q.push_back('{1'b1, 16'h00A5});
        @(posedge clk); @(negedge clk); mem_cmd = M_NONE;
        repeat (3) @(negedge clk);
        do_access(M_READ, 9'h100, 16'h0, 1'b1, 16'h1111, 1'b0, lat);
    endtask

    task automatic test_io_out();
        int lat;
        do_access(M_WRITE, 9'h180, 16'h00FF, 1'b0, 16'h0, 1'b0, lat);
        checks++; if (out_port !== 32'h0000_00FF) begin errors++; $display("FAIL out_wr0: got %h expected 000000ff", out_port); end
        do_access(M_READ, 9'h180, 16'h0, 1'b1, 16'h00FF, 1'b0, lat);
        do_access(M_WRITE, 9'h181, 16'hABCD, 1'b0, 16'h0, 1'b0, lat);
        checks++; if (out_port !== 32'hABCD_00FF) begin errors++; $display("FAIL out_wr1: got %h expected abcd00ff", out_port); end
        do_access(M_READ, 9'h181, 16'h0, 1'b1, 16'hABCD, 1'b0, lat);
        checks++; if (bus_err !== 0) begin errors++; $display("FAIL out_no_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_err();
        int lat;
        do_access(M_READ, 9'h150, 16'h0, 1'b1, 16'h0, 1'b0, lat);
        checks++; if (bus_err !== 1) begin errors++; $display("FAIL err_unmapped_rd: got %b expected 1", bus_err); end
        checks++; if (lat != 1)      begin errors++; $display("FAIL err_lat: got %0d expected 1", lat); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (bus_err !== 0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus_err); end
        do_access(M_READ, 9'h181, 16'h0, 1'b1, 16'hABCD, 1'b0, lat);
        do_access(M_ILLEGAL, 9'h005, 16'h0, 1'b1, 16'h0, 1'b0, lat);
        checks++; if (bus_err !== 1) begin errors++; $display("FAIL err_illegal: got %b expected 1", bus_err); end
        checks++; if (ram[5] !== 16'h1234) begin errors++; $display("FAIL err_illegal_nowrite: got %h expected 1234", ram[5]); end
        // Write to an input offset with err_clr in the same cycle: error must win.
        do_access(M_WRITE, 9'h100, 16'h7777, 1'b0, 16'h0, 1'b1, lat);
        checks++; if (bus_err !== 1) begin errors++; $display("FAIL err_clr_vs_evt: got %b expected 1", bus_err); end
        do_access(M_WRITE, 9'h182, 16'h5555, 1'b0, 16'h0, 1'b0, lat);
        checks++; if (out_port !== 32'hABCD_00FF) begin errors++; $display("FAIL err_no_port_wr: got %h expected abcd00ff", out_port); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [DW-1:0] d [6];
        for (int i = 0; i < 6; i++) begin
            d[i] = DW'($urandom) | 16'h0001;
            do_access(M_WRITE, 9'(8'h40 + i * 3), d[i], 1'b0, 16'h0, 1'b0, lat);
        end
        for (int i = 5; i >= 0; i--) begin
            do_access(M_READ, 9'(8'h40 + i * 3), 16'h0, 1'b1, d[i], 1'b0, lat);
            checks++; if (lat != LAT + 1) begin errors++; $display("FAIL b2b_lat%0d: got %0d expected %0d", i, lat, LAT + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int w0, bad;
        w0 = wr_cnt;
        @(negedge clk);
        mem_cmd = M_READ; mem_addr = 9'h0FF;
        sb_q.push_back('{1'b1, 16'hBEEF});
        @(posedge clk);
        @(negedge clk);
        mem_cmd = M_NONE; reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_ready !== 0)  begin errors++; $display("FAIL mid_ready: got %b expected 0", mem_ready); end
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL mid_rdata: got %h expected 0", rdata); end
        checks++; if (out_port !== '0)  begin errors++; $display("FAIL mid_out_port: got %h expected 0", out_port); end
        checks++; if (bus_err !== 0)    begin errors++; $display("FAIL mid_bus_err: got %b expected 0", bus_err); end
        checks++; if (ram_write !== 0)  begin errors++; $display("FAIL mid_ram_write: got %b expected 0", ram_write); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_ready) bad++;
        end
        checks++; if (bad != 0)          begin errors++; $display("FAIL mid_no_ready: got %0d pulses expected 0", bad); end
        checks++; if (sb_q.size() != 1)  begin errors++; $display("FAIL mid_pending: got %0d expected 1", sb_q.size()); end
        checks++; if (wr_cnt != w0)      begin errors++; $display("FAIL mid_no_write: got %0d expected 0", wr_cnt - w0); end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io_in();
        test_io_out();
        test_err();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 9, CPU address width; MSB selects RAM (0) or I/O (1).
REQ-003 SHALL have parameter N_IN, default 2 (range 1..8), number of input ports.
REQ-004 SHALL have parameter N_OUT, default 2 (range 1..8), number of output ports.
REQ-005 SHALL have parameter RAM_LAT, default 1 (range 1..4), RAM read latency in cycles.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-007 SHALL have: mem_cmd  in  2  00 NONE, 01 READ, 10 WRITE, 11 illegal.
REQ-008 SHALL have: mem_addr  in  ADDR_W  access address.
REQ-009 SHALL have: wdata  in  DATA_W  write data from CPU.
REQ-010 SHALL have: rdata  out  DATA_W  registered read data to CPU.
REQ-011 SHALL have: mem_ready  out  1  one-cycle access-complete pulse.
REQ-012 SHALL have: ram_addr  out  ADDR_W-1; ram_write  out  1; ram_din  out  DATA_W; ram_dout  in  DATA_W.
REQ-013 SHALL have: in_port  in  N_IN*DATA_W  asynchronous input ports, port i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have: out_port  out  N_OUT*DATA_W  registered output ports, same packing.
REQ-015 SHALL have: bus_err  out  1  sticky error flag; err_clr  in  1  clears bus_err.

Function
REQ-016 Address map SHALL be: MSB=0 -> RAM at mem_addr[ADDR_W-2:0]; I/O offset = mem_addr[7:0]; offsets 0x00..N_IN-1 input ports (read-only); offsets 0x80..0x80+N_OUT-1 output ports (read/write); all other I/O offsets are unmapped.
REQ-017 FSM SHALL have states IDLE, RAM_WAIT, DONE; it accepts a command only in IDLE when mem_cmd != NONE.
REQ-018 RAM read: IDLE -> RAM_WAIT; ram_addr driven; after exactly RAM_LAT cycles in RAM_WAIT, ram_dout SHALL be captured into rdata -> DONE.
REQ-019 RAM write: ram_write SHALL be high for exactly the acceptance cycle with ram_addr and ram_din = wdata; IDLE -> DONE.
REQ-020 I/O read: the selected port value SHALL be captured into rdata at the acceptance edge; IDLE -> DONE.
REQ-021 I/O write to an output port SHALL update that port at the acceptance edge; IDLE -> DONE; other ports unchanged.
REQ-022 In DONE, mem_ready SHALL be 1 for exactly one cycle; DONE -> IDLE unconditionally; a command present in IDLE is always a new access.
REQ-023 Latency from acceptance to mem_ready SHALL be RAM_LAT+1 cycles for RAM reads and 1 cycle for all other accesses.
REQ-024 Each in_port SHALL pass through a 2-flop synchronizer; I/O reads return the synchronized value.
REQ-025 Reads of output-port offsets SHALL return the current out_port register value.
REQ-026 An unmapped access, an I/O write to an input offset, or mem_cmd=11 SHALL set bus_err, perform no write, load rdata=0 on reads (and on 11), and still complete through DONE with mem_ready.
REQ-027 rdata SHALL hold its value except when a read completes.
REQ-028 Simultaneous err_clr and a new error event SHALL leave bus_err=1.
REQ-029 ram_write SHALL never assert outside IDLE acceptance of a RAM write.

Reset
REQ-030 reset SHALL force state IDLE, rdata=0, mem_ready=0, ram_write=0, out_port=0, bus_err=0, synchronizer flops=0.
REQ-031 reset asserted mid-access SHALL abort it with no mem_ready pulse and no further RAM or port write.

Structure
REQ-032 The shared package SHALL hold the M_NONE/M_READ/M_WRITE encodings, FSM state encodings and I/O offset constants (IN_BASE=0x00, OUT_BASE=0x80).
REQ-033 A sub-module mmio_sync2 (2-flop synchronizer, width DATA_W, synchronous reset) SHALL be instantiated once per input port.

Verification
REQ-034 RAM_LAT=2: write 0x1234 to 0x005, read 0x005 -> ram_write one cycle; read mem_ready 3 cycles after acceptance; rdata=0x1234.
REQ-035 in_port0=0x00A5 held 2 cycles, read 0x100 -> rdata=0x00A5, mem_ready 1 cycle after acceptance.
REQ-036 Write 0x00FF to 0x180 -> out_port0=0x00FF, out_port1 unchanged; read 0x180 -> rdata=0x00FF.
REQ-037 Read 0x150, then mem_cmd=11 -> bus_err=1, rdata=0, mem_ready pulses each; err_clr together with a new error -> bus_err stays 1.
REQ-038 Assert reset during RAM_WAIT -> no mem_ready, state IDLE, all outputs 0 next cycle.
